// File: rtl/if_defs.sv
// Shared fetch-path definitions: reset PC, PC increment and the queued entry layout.
package if_defs;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Fetch targets are word addresses; the low two bits are ignored.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch-entry FIFO with first-word-fall-through head, synchronous flush and occupancy count.
module fetch_fifo
  import if_defs::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  fetch_entry_t     i_entry,
  input  logic             i_pop,
  input  logic             i_flush,
  output fetch_entry_t     o_head,
  output logic [CNT_W-1:0] o_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Storage and pointers; flush has priority over push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_entry;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Push into a full queue without a pop, or pop from empty, is a bug upstream.
  always_ff @(posedge clk) begin
    if (!rst && !i_flush) begin
      assert (!(i_push && !i_pop && (r_count == CNT_W'(DEPTH))));
      assert (!(i_pop && (r_count == '0)));
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: in-order imem requests, response queue toward IF/ID, redirect flush.
module if_fetch_queue
  import if_defs::*;
#(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        out_ready
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OS_W  = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]      r_pc;
  logic [31:0]      r_resp_pc;
  logic [OS_W-1:0]  r_inflight;
  logic [OS_W-1:0]  r_drop;

  logic [CNT_W-1:0] w_count;
  logic [OS_W-1:0]  w_live;
  logic             w_issue;
  logic             w_push;
  logic             w_pop;
  logic             w_out_valid;
  logic [31:0]      w_target;
  fetch_entry_t     w_head;
  fetch_entry_t     w_entry;

  // Outstanding responses that will still land in the queue reserve a slot now.
  assign w_live   = r_inflight - r_drop;
  assign w_issue  = !rst && !redirect_valid
                  && (32'(r_inflight) < MAX_OUTSTANDING)
                  && ((32'(w_count) + 32'(w_live)) < DEPTH);
  assign w_push   = imem_rvalid && !redirect_valid && (r_drop == '0);
  assign w_out_valid = !rst && (w_count != '0) && !redirect_valid;
  assign w_pop    = w_out_valid && out_ready;
  assign w_target = word_align(redirect_pc);
  assign w_entry  = '{pc: r_resp_pc, instr: imem_rdata};

  // Fetch PC and response PC track issue and accepted returns respectively.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc      <= RESET_PC;
      r_resp_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc      <= w_target;
      r_resp_pc <= w_target;
    end else begin
      if (w_issue) r_pc      <= r_pc + PC_STEP;
      if (w_push)  r_resp_pc <= r_resp_pc + PC_STEP;
    end
  end

  // In-flight and stale-response counters; a redirect marks everything still out as stale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= '0;
      r_drop     <= '0;
    end else begin
      r_inflight <= r_inflight + OS_W'(w_issue) - OS_W'(imem_rvalid);
      if (redirect_valid) begin
        r_drop <= r_inflight - OS_W'(imem_rvalid);
      end else if (imem_rvalid && (r_drop != '0)) begin
        r_drop <= r_drop - OS_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(imem_rvalid && (r_inflight == '0)));
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_entry (w_entry),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign imem_req  = w_issue;
  assign imem_addr = r_pc;
  assign out_valid = w_out_valid;
  assign out_pc    = w_head.pc;
  assign out_instr = w_head.instr;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue with a variable-latency in-order imem model.
module tb_if_fetch_queue;
  import if_defs::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAXO  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready = 1'b0;

  always #5 clk = ~clk;

  if_fetch_queue #(
    .DEPTH           (DEPTH),
    .MAX_OUTSTANDING (MAXO),
    .RESET_PC        (32'h0000_3000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_ready      (out_ready)
  );

  typedef struct {
    logic [31:0] pc;
    int          due;
    bit          stale;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  req_t        pend[$];
  exp_t        sb[$];
  logic [31:0] pops[$];
  int          cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;
  int          g_lat = 1;
  bit          g_rst = 1'b1;
  bit          g_redir = 1'b0;
  bit          g_ready = 1'b0;
  logic [31:0] g_redir_pc = '0;
  logic [31:0] m_pc = 32'h0000_3000;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A00_C3C3;
  endfunction

  task automatic model_reset();
    pend.delete();
    sb.delete();
    m_pc = 32'h0000_3000;
  endtask

  // One clock: drive imem/ID inputs at negedge, compare against the model, then advance it.
  task automatic step();
    int   live;
    bit   ereq;
    bit   evalid;
    bit   rv;
    exp_t head;
    @(negedge clk);
    cyc++;
    rst = g_rst;
    rv  = !g_rst && (pend.size() > 0) && (pend[0].due <= cyc);
    imem_rvalid    = rv;
    imem_rdata     = rv ? mem_word(pend[0].pc) : 32'h0;
    redirect_valid = g_redir;
    redirect_pc    = g_redir_pc;
    out_ready      = g_ready;
    #1;
    if (g_rst) begin
      n_total++;
      if (imem_req !== 1'b0 || out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0)
        $display("FAIL reset_outputs cyc=%0d: req=%b valid=%b pc=%h instr=%h, required all 0",
                 cyc, imem_req, out_valid, out_pc, out_instr);
      else n_pass++;
      model_reset();
      return;
    end
    live = 0;
    foreach (pend[i]) if (!pend[i].stale) live++;
    ereq   = !g_redir && (pend.size() < int'(MAXO)) && (sb.size() + live < int'(DEPTH));
    evalid = (sb.size() != 0) && !g_redir;
    n_total++;
    if (imem_req !== ereq)
      $display("FAIL imem_req cyc=%0d: got %b, required %b", cyc, imem_req, ereq);
    else n_pass++;
    if (ereq) begin
      n_total++;
      if (imem_addr !== m_pc)
        $display("FAIL imem_addr cyc=%0d: got %h, required %h", cyc, imem_addr, m_pc);
      else n_pass++;
    end
    n_total++;
    if (out_valid !== evalid)
      $display("FAIL out_valid cyc=%0d: got %b, required %b", cyc, out_valid, evalid);
    else n_pass++;
    if (evalid) begin
      head = sb[0];
      n_total++;
      if (out_pc !== head.pc || out_instr !== head.instr)
        $display("FAIL head cyc=%0d: got pc=%h instr=%h, required pc=%h instr=%h",
                 cyc, out_pc, out_instr, head.pc, head.instr);
      else n_pass++;
      if (g_ready) begin
        pops.push_back(out_pc);
        void'(sb.pop_front());
      end
    end
    n_total++;
    if (dut.r_drop > dut.r_inflight || dut.u_fifo.o_count > DEPTH || dut.r_inflight > MAXO)
      $display("FAIL counters cyc=%0d: drop=%0d inflight=%0d count=%0d out of range",
               cyc, dut.r_drop, dut.r_inflight, dut.u_fifo.o_count);
    else n_pass++;
    if (rv) begin
      if (!g_redir && !pend[0].stale) sb.push_back('{pend[0].pc, mem_word(pend[0].pc)});
      void'(pend.pop_front());
    end
    if (g_redir) begin
      sb.delete();
      foreach (pend[i]) pend[i].stale = 1'b1;
      m_pc = g_redir_pc & ~32'h3;
    end else if (ereq) begin
      pend.push_back('{m_pc, cyc + g_lat, 1'b0});
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic apply_reset(input int lat, input bit rdy);
    g_rst = 1'b1; g_redir = 1'b0; g_lat = lat; g_ready = rdy;
    repeat (3) step();
    g_rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset(1, 1'b1);
    n_total++;
    if (dut.u_fifo.o_count !== 3'd0 || dut.r_inflight !== 2'd0 || dut.r_drop !== 2'd0)
      $display("FAIL reset_state: count=%0d inflight=%0d drop=%0d, required 0/0/0",
               dut.u_fifo.o_count, dut.r_inflight, dut.r_drop);
    else n_pass++;
  endtask

  task automatic test_latency();
    logic [31:0] want;
    step();
    n_total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h3000)
      $display("FAIL first_req: req=%b addr=%h, required 1/00003000", imem_req, imem_addr);
    else n_pass++;
    step();
    for (int k = 0; k < 3; k++) begin
      step();
      want = 32'h3000 + 32'(4 * k);
      n_total++;
      if (out_valid !== 1'b1 || out_pc !== want)
        $display("FAIL latency_%0d: valid=%b pc=%h, required 1/%h", k, out_valid, out_pc, want);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int          nreq;
    logic [31:0] first_addr;
    bit          got;
    apply_reset(1, 1'b0);
    nreq = 0;
    repeat (10) begin
      step();
      if (imem_req) nreq++;
    end
    n_total++;
    if (nreq != 4 || imem_req !== 1'b0)
      $display("FAIL stall_requests: got %0d req (req now %b), required 4 (0)", nreq, imem_req);
    else n_pass++;
    g_ready = 1'b1;
    pops.delete();
    got = 1'b0;
    first_addr = '0;
    for (int t = 0; t < 20 && pops.size() < 4; t++) begin
      step();
      if (imem_req && !got) begin got = 1'b1; first_addr = imem_addr; end
    end
    n_total++;
    if (pops.size() < 4)
      $display("FAIL drain_timeout: got %0d pops, required 4", pops.size());
    else if (pops[0] !== 32'h3000 || pops[1] !== 32'h3004 || pops[2] !== 32'h3008 || pops[3] !== 32'h300C)
      $display("FAIL drain_order: got %h %h %h %h, required 3000 3004 3008 300C",
               pops[0], pops[1], pops[2], pops[3]);
    else n_pass++;
    n_total++;
    if (!got || first_addr !== 32'h3010)
      $display("FAIL resume_addr: got %h (seen=%b), required 00003010", first_addr, got);
    else n_pass++;
  endtask

  task automatic test_redirect_inflight();
    bit bad;
    apply_reset(3, 1'b1);
    for (int t = 0; t < 30 && m_pc != 32'h3010; t++) step();
    g_redir = 1'b1; g_redir_pc = 32'h3040;
    step();
    g_redir = 1'b0;
    #5;
    n_total++;
    if (dut.r_drop !== 2'd2)
      $display("FAIL drop_after_redirect: got %0d, required 2", dut.r_drop);
    else n_pass++;
    pops.delete();
    for (int t = 0; t < 30 && pops.size() < 3; t++) step();
    n_total++;
    if (pops.size() == 0 || pops[0] !== 32'h3040)
      $display("FAIL redirect_target: got %0d pops, first %h, required 00003040",
               pops.size(), (pops.size() != 0) ? pops[0] : 32'h0);
    else n_pass++;
    bad = 1'b0;
    foreach (pops[i]) if (pops[i] == 32'h3008 || pops[i] == 32'h300C) bad = 1'b1;
    n_total++;
    if (bad || dut.r_drop !== 2'd0)
      $display("FAIL stale_leak: stale pc seen=%b drop=%0d, required 0/0", bad, dut.r_drop);
    else n_pass++;
  endtask

  task automatic test_redirect_same_cycle();
    apply_reset(1, 1'b1);
    repeat (6) step();
    g_redir = 1'b1; g_redir_pc = 32'h3101;
    step();
    n_total++;
    if (out_valid !== 1'b0 || imem_req !== 1'b0 || imem_rvalid !== 1'b1)
      $display("FAIL redirect_cycle: valid=%b req=%b rvalid=%b, required 0/0/1",
               out_valid, imem_req, imem_rvalid);
    else n_pass++;
    g_redir = 1'b0;
    pops.delete();
    step();
    n_total++;
    if (dut.u_fifo.o_count !== 3'd0 || imem_req !== 1'b1 || imem_addr !== 32'h3100)
      $display("FAIL after_redirect: count=%0d req=%b addr=%h, required 0/1/00003100",
               dut.u_fifo.o_count, imem_req, imem_addr);
    else n_pass++;
    for (int t = 0; t < 20 && pops.size() < 1; t++) step();
    n_total++;
    if (pops.size() == 0 || pops[0] !== 32'h3100)
      $display("FAIL redirect_first_pop: got %0d pops, required first 00003100", pops.size());
    else n_pass++;
  endtask

  task automatic test_full_stream();
    bit order_ok;
    apply_reset(1, 1'b0);
    for (int t = 0; t < 20 && sb.size() < 4; t++) step();
    repeat (2) step();
    n_total++;
    if (dut.u_fifo.o_count !== 3'd4 || imem_req !== 1'b0)
      $display("FAIL full_hold: count=%0d req=%b, required 4/0", dut.u_fifo.o_count, imem_req);
    else n_pass++;
    g_ready = 1'b1;
    pops.delete();
    repeat (16) step();
    order_ok = 1'b1;
    foreach (pops[i]) if (pops[i] !== 32'h3000 + 32'(4 * i)) order_ok = 1'b0;
    n_total++;
    if (!order_ok || pops.size() < 12)
      $display("FAIL stream_order: pops=%0d in_order=%b, required >=12/1", pops.size(), order_ok);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    apply_reset(2, 1'b1);
    repeat (8) step();
    #2;
    g_rst = 1'b1;
    rst = 1'b1;
    imem_rvalid = 1'b0;
    #1;
    n_total++;
    if (imem_req !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL async_reset: req=%b valid=%b, required 0/0", imem_req, out_valid);
    else n_pass++;
    model_reset();
    repeat (2) step();
    g_rst = 1'b0;
    step();
    n_total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h3000 || dut.u_fifo.o_count !== 3'd0 ||
        dut.r_inflight !== 2'd0 || dut.r_drop !== 2'd0)
      $display("FAIL restart: req=%b addr=%h count=%0d inflight=%0d drop=%0d, required 1/00003000/0/0/0",
               imem_req, imem_addr, dut.u_fifo.o_count, dut.r_inflight, dut.r_drop);
    else n_pass++;
    repeat (6) step();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_same_cycle();
    test_full_stream();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
